// File: rtl/conv1_dataflow_sequencer.sv
// Start/ready/done sequencer for the four-stage conv1 dataflow region, with
// per-stage ready synchronisation, sink completion counting and a stall watchdog.
module conv1_dataflow_sequencer #(
  parameter int unsigned         NUM_STAGES = 4,
  parameter int unsigned         REPS_W     = 16,
  parameter int unsigned         WDOG_W     = 20,
  parameter logic [WDOG_W-1:0]   WDOG_LIMIT = 20'hFFFFF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ap_start,
  input  logic [REPS_W-1:0]     num_reps,
  output logic                  ap_ready,
  output logic                  ap_done,
  output logic                  ap_idle,
  output logic [NUM_STAGES-1:0] stage_start,
  input  logic [NUM_STAGES-1:0] stage_ready,
  input  logic [NUM_STAGES-1:0] stage_done,
  output logic [REPS_W-1:0]     rep_count,
  output logic                  stall_flag,
  output logic [NUM_STAGES-1:0] stall_mask
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_STALL = 3'd4;

  localparam logic [NUM_STAGES-1:0] SINK_BIT = {1'b1, {(NUM_STAGES-1){1'b0}}};

  logic [2:0]            state_q, state_d;
  logic [REPS_W-1:0]     reps_q, reps_d;
  logic [REPS_W-1:0]     rep_cnt_q, rep_cnt_d;
  logic [REPS_W-1:0]     done_cnt_q, done_cnt_d;
  logic [NUM_STAGES-1:0] ready_seen_q, ready_seen_d;
  logic [WDOG_W-1:0]     wdog_q, wdog_d;
  logic [NUM_STAGES-1:0] stall_mask_q, stall_mask_d;
  logic                  ap_ready_q, ap_ready_d;

  logic [NUM_STAGES-1:0] accepted;
  logic [NUM_STAGES-1:0] seen_all;
  logic [REPS_W-1:0]     rep_inc;
  logic [REPS_W-1:0]     done_eff;
  logic                  active;
  logic                  sink_done;
  logic                  done_inc;
  logic                  progress;
  logic                  stall_hit;
  logic                  unused_done_bits;

  assign unused_done_bits = ^stage_done[NUM_STAGES-2:0];

  // Starts depend only on registered state, so there is no path from stage_ready.
  assign stage_start = (state_q == S_RUN) ? ~ready_seen_q : '0;
  assign ap_ready    = ap_ready_q;
  assign ap_done     = (state_q == S_DONE);
  assign ap_idle     = (state_q == S_IDLE);
  assign stall_flag  = (state_q == S_STALL);
  assign stall_mask  = stall_mask_q;
  assign rep_count   = rep_cnt_q;

  always_comb begin
    accepted  = stage_start & stage_ready;
    seen_all  = ready_seen_q | accepted;
    rep_inc   = rep_cnt_q + 1'b1;
    active    = (state_q == S_RUN) || (state_q == S_DRAIN);
    sink_done = stage_done[NUM_STAGES-1];
    progress  = (|accepted) || sink_done;
    done_inc  = active && sink_done && (done_cnt_q != reps_q);
    done_eff  = done_cnt_q + {{(REPS_W-1){1'b0}}, done_inc};
    stall_hit = active && !progress && (wdog_q == WDOG_LIMIT - 1'b1);

    state_d      = state_q;
    reps_d       = reps_q;
    rep_cnt_d    = rep_cnt_q;
    done_cnt_d   = done_cnt_q;
    ready_seen_d = ready_seen_q;
    stall_mask_d = stall_mask_q;
    ap_ready_d   = 1'b0;
    wdog_d       = '0;

    if (active) begin
      done_cnt_d = done_eff;
      if (!progress && !stall_hit) begin
        wdog_d = wdog_q + 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (ap_start) begin
          reps_d       = num_reps;
          rep_cnt_d    = '0;
          done_cnt_d   = '0;
          ready_seen_d = '0;
          state_d      = (num_reps != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (&seen_all) begin
          rep_cnt_d    = rep_inc;
          ready_seen_d = '0;
          if (rep_inc == reps_q) begin
            ap_ready_d = 1'b1;
            state_d    = S_DRAIN;
          end
        end else begin
          ready_seen_d = seen_all;
          if (stall_hit) begin
            state_d      = S_STALL;
            stall_mask_d = ~ready_seen_q;
          end
        end
      end
      S_DRAIN: begin
        if (done_eff == reps_q) begin
          state_d = S_DONE;
        end else if (stall_hit) begin
          state_d      = S_STALL;
          stall_mask_d = SINK_BIT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_STALL: state_d = S_STALL;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      reps_q       <= '0;
      rep_cnt_q    <= '0;
      done_cnt_q   <= '0;
      ready_seen_q <= '0;
      wdog_q       <= '0;
      stall_mask_q <= '0;
      ap_ready_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      reps_q       <= reps_d;
      rep_cnt_q    <= rep_cnt_d;
      done_cnt_q   <= done_cnt_d;
      ready_seen_q <= ready_seen_d;
      wdog_q       <= wdog_d;
      stall_mask_q <= stall_mask_d;
      ap_ready_q   <= ap_ready_d;
    end
  end

endmodule
